alu_share_arb: RTL and testbench

Round-robin arbiter and two-stage sequencer that shares one combinational ALU (alu_t) between NREQ requesters, e.g. execute stage and address generation. Accepts one operation per cycle via valid/ready, drives the ALU from an issue register, and captures the ALU output into a response register. The response is tagged with the requester ID. Sits in the exe stage between requesters and the single ALU instance.

---
 rtl/alu_share_arb.sv | 138 +++++++++++++
 tb/tb_alu_share_arb.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arb.sv
// Round-robin arbiter and two-stage issue/response sequencer that shares one
// combinational ALU between NREQ requesters; responses carry the requester ID.
package alufnt;
  typedef enum logic [2:0] {add, sub, sl, sr, sra, xoro, oro, ando} alu_func_t;
endpackage

module alu_share_arb #(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [NREQ-1:0]     req_valid,
  input  alufnt::alu_func_t   req_fn  [NREQ],
  input  logic [31:0]         req_in1 [NREQ],
  input  logic [31:0]         req_in2 [NREQ],
  output logic [NREQ-1:0]     req_ready,
  output alufnt::alu_func_t   alu_fn,
  output logic [31:0]         alu_in1,
  output logic [31:0]         alu_in2,
  input  logic [31:0]         alu_out,
  output logic                resp_valid,
  output logic [IDW-1:0]      resp_id,
  output logic [31:0]         resp_data,
  input  logic                resp_ready
);

  localparam int IW = IDW + 1;

  // Issue register (S1)
  logic              s1_valid;
  alufnt::alu_func_t s1_fn;
  logic [31:0]       s1_in1;
  logic [31:0]       s1_in2;
  logic [IDW-1:0]    s1_id;

  // Response register (S2)
  logic              s2_valid;
  logic [IDW-1:0]    s2_id;
  logic [31:0]       s2_data;

  logic [IDW-1:0]    rr_ptr;
  logic [IDW-1:0]    grant;
  logic [IDW-1:0]    rr_next;
  logic              grant_found;
  logic [IW-1:0]     idx;
  logic              s2_free;
  logic              s1_adv;
  logic              s1_free;
  logic              accept;

  assign s2_free = !s2_valid || resp_ready;
  assign s1_adv  = s1_valid && s2_free;
  assign s1_free = !s1_valid || s1_adv;

  // Search req_valid starting at rr_ptr, wrapping modulo NREQ.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    grant       = '0;
    grant_found = 1'b0;
    idx         = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = {1'b0, rr_ptr} + IW'(i);
      if (idx >= IW'(NREQ)) idx = idx - IW'(NREQ);
      if (!grant_found && req_valid[idx[IDW-1:0]]) begin
        grant       = idx[IDW-1:0];
        grant_found = 1'b1;
      end
    end
  end

  // Reset also masks ready so nothing is offered while the pipeline is held.
  always_comb begin
    req_ready = '0;
    if (rst && grant_found && s1_free && !flush) req_ready[grant] = 1'b1;
  end

  assign accept  = req_valid[grant] && req_ready[grant];
  assign rr_next = (grant == IDW'(NREQ - 1)) ? '0 : grant + IDW'(1);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the data registers are reset too, since they drive the ALU and the response port directly.
      s1_valid <= 1'b0;
      s1_fn    <= alufnt::add;
      s1_in1   <= '0;
      s1_in2   <= '0;
      s1_id    <= '0;
      rr_ptr   <= '0;
    end else begin
      if (flush) begin
        s1_valid <= 1'b0;
      end else if (accept) begin
        s1_valid <= 1'b1;
        s1_fn    <= req_fn[grant];
        s1_in1   <= req_in1[grant];
        s1_in2   <= req_in2[grant];
        s1_id    <= grant;
        rr_ptr   <= rr_next;
      end else if (s1_free) begin
        s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid <= 1'b0;
      s2_id    <= '0;
      s2_data  <= '0;
    end else begin
      if (s1_adv) begin
        s2_id   <= s1_id;
        s2_data <= alu_out;
      end
      if (flush)           s2_valid <= 1'b0;
      else if (s1_adv)     s2_valid <= 1'b1;
      else if (resp_ready) s2_valid <= 1'b0;
    end
  end

  assign alu_fn     = s1_fn;
  assign alu_in1    = s1_in1;
  assign alu_in2    = s1_in2;
  assign resp_valid = s2_valid;
  assign resp_id    = s2_id;
  assign resp_data  = s2_data;

  // A requester left waiting must keep its request and operands unchanged.
  for (genvar r = 0; r < NREQ; r++) begin : g_hold
    a_req_hold: assert property (@(posedge clk) disable iff (!rst)
      (req_valid[r] && !req_ready[r]) |=>
        (req_valid[r] && $stable(req_fn[r]) && $stable(req_in1[r]) && $stable(req_in2[r])));
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Scoreboard bench for alu_share_arb: NREQ=2 instance for the main flow,
// NREQ=3 instance for round-robin wrap; the ALU itself is modelled here.
`timescale 1ns/1ps
module tb_alu_share_arb;
  import alufnt::*;

  typedef struct packed {
    alu_func_t   fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } op_t;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance A, NREQ=2
  logic [1:0]  a_req_valid, a_req_ready;
  alu_func_t   a_req_fn  [2];
  logic [31:0] a_req_in1 [2];
  logic [31:0] a_req_in2 [2];
  alu_func_t   a_alu_fn;
  logic [31:0] a_alu_in1, a_alu_in2, a_alu_out;
  logic        a_resp_valid, a_resp_ready;
  logic [0:0]  a_resp_id;
  logic [31:0] a_resp_data;

  // Instance B, NREQ=3
  logic [2:0]  b_req_valid, b_req_ready;
  alu_func_t   b_req_fn  [3];
  logic [31:0] b_req_in1 [3];
  logic [31:0] b_req_in2 [3];
  alu_func_t   b_alu_fn;
  logic [31:0] b_alu_in1, b_alu_in2, b_alu_out;
  logic        b_resp_valid, b_resp_ready;
  logic [1:0]  b_resp_id;
  logic [31:0] b_resp_data;

  alu_share_arb #(.NREQ(2)) u_dut_a (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(a_req_valid), .req_fn(a_req_fn), .req_in1(a_req_in1), .req_in2(a_req_in2),
    .req_ready(a_req_ready),
    .alu_fn(a_alu_fn), .alu_in1(a_alu_in1), .alu_in2(a_alu_in2), .alu_out(a_alu_out),
    .resp_valid(a_resp_valid), .resp_id(a_resp_id), .resp_data(a_resp_data),
    .resp_ready(a_resp_ready)
  );

  alu_share_arb #(.NREQ(3)) u_dut_b (
    .clk(clk), .rst(rst), .flush(1'b0),
    .req_valid(b_req_valid), .req_fn(b_req_fn), .req_in1(b_req_in1), .req_in2(b_req_in2),
    .req_ready(b_req_ready),
    .alu_fn(b_alu_fn), .alu_in1(b_alu_in1), .alu_in2(b_alu_in2), .alu_out(b_alu_out),
    .resp_valid(b_resp_valid), .resp_id(b_resp_id), .resp_data(b_resp_data),
    .resp_ready(b_resp_ready)
  );

  function automatic logic [31:0] alu_model(alu_func_t fn, logic [31:0] x, logic [31:0] y);
    case (fn)
      add:     return x + y;
      sub:     return x - y;
      sl:      return x << y[4:0];
      sr:      return x >> y[4:0];
      sra:     return $signed(x) >>> y[4:0];
      xoro:    return x ^ y;
      oro:     return x | y;
      ando:    return x & y;
      default: return '0;
    endcase
  endfunction

  assign a_alu_out = alu_model(a_alu_fn, a_alu_in1, a_alu_in2);
  assign b_alu_out = alu_model(b_alu_fn, b_alu_in1, b_alu_in2);

  function automatic op_t mk(alu_func_t fn, logic [31:0] a, logic [31:0] b, logic [31:0] exp);
    op_t o;
    o.fn = fn; o.a = a; o.b = b; o.exp = exp;
    return o;
  endfunction

  function automatic rsp_t mk_rsp(int id, logic [31:0] data);
    rsp_t r;
    r.id = 2'(id); r.data = data;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  op_t  q0[$], q1[$];
  rsp_t sb_a[$], sb_b[$];
  int   acc_log[$];
  int   resp_cnt_a = 0;
  int   resp_cnt_b = 0;

  // Driver for instance A: presents queue heads, records accepts, pushes expectations.
  initial begin : drv_a
    logic [1:0] pop;
    pop = '0;
    a_req_valid = '0;
    for (int r = 0; r < 2; r++) begin
      a_req_fn[r] = add; a_req_in1[r] = '0; a_req_in2[r] = '0;
    end
    forever begin
      @(posedge clk); #2;
      if (pop[0] && q0.size() != 0) void'(q0.pop_front());
      if (pop[1] && q1.size() != 0) void'(q1.pop_front());
      pop = '0;
      a_req_valid[0] = (q0.size() != 0);
      a_req_valid[1] = (q1.size() != 0);
      if (q0.size() != 0) begin
        a_req_fn[0] = q0[0].fn; a_req_in1[0] = q0[0].a; a_req_in2[0] = q0[0].b;
      end
      if (q1.size() != 0) begin
        a_req_fn[1] = q1[0].fn; a_req_in1[1] = q1[0].a; a_req_in2[1] = q1[0].b;
      end
      @(negedge clk);
      check("a_ready_onehot", 32'($countones(a_req_ready) <= 1), 32'd1);
      if (a_req_valid[0] && a_req_ready[0]) begin
        pop[0] = 1'b1; acc_log.push_back(0); sb_a.push_back(mk_rsp(0, q0[0].exp));
      end
      if (a_req_valid[1] && a_req_ready[1]) begin
        pop[1] = 1'b1; acc_log.push_back(1); sb_a.push_back(mk_rsp(1, q1[0].exp));
      end
    end
  end

  // Response monitor for both instances.
  initial begin : mon
    rsp_t e;
    forever begin
      @(negedge clk);
      if (a_resp_valid && a_resp_ready) begin
        resp_cnt_a++;
        if (sb_a.size() == 0) begin
          checks++; failures++;
          $display("FAIL a_resp_unexpected: got id=%0d data=0x%08h, expected no response", a_resp_id, a_resp_data);
        end else begin
          e = sb_a.pop_front();
          check("a_resp_id", 32'(a_resp_id), 32'(e.id));
          check("a_resp_data", a_resp_data, e.data);
        end
      end
      if (b_resp_valid && b_resp_ready) begin
        resp_cnt_b++;
        if (sb_b.size() == 0) begin
          checks++; failures++;
          $display("FAIL b_resp_unexpected: got id=%0d data=0x%08h, expected no response", b_resp_id, b_resp_data);
        end else begin
          e = sb_b.pop_front();
          check("b_resp_id", 32'(b_resp_id), 32'(e.id));
          check("b_resp_data", b_resp_data, e.data);
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle_a(input string name);
    int t;
    t = 0;
    do begin @(posedge clk); t++; end
    while ((q0.size() + q1.size() + sb_a.size()) != 0 && t < 200);
    #1;
    check(name, 32'(t < 200), 32'd1);
  endtask

  task automatic b_step(input logic [2:0] v, input logic [2:0] exp_ready, input string name);
    tick(1);
    b_req_valid = v;
    @(negedge clk);
    check(name, 32'(b_req_ready), 32'(exp_ready));
  endtask

  initial begin : main
    int base;
    int exp_order[4];
    exp_order = '{0, 1, 0, 1};
    rst = 1'b1; flush = 1'b0; a_resp_ready = 1'b0; b_resp_ready = 1'b0;
    b_req_valid = '0;
    for (int r = 0; r < 3; r++) begin
      b_req_fn[r] = add; b_req_in1[r] = '0; b_req_in2[r] = '0;
    end
    #1 rst = 1'b0;

    // Reset state
    tick(2);
    @(negedge clk);
    check("rst_resp_valid", 32'(a_resp_valid), 32'd0);
    check("rst_resp_id", 32'(a_resp_id), 32'd0);
    check("rst_resp_data", a_resp_data, 32'd0);
    check("rst_alu_fn", 32'(a_alu_fn), 32'(add));
    check("rst_alu_in1", a_alu_in1, 32'd0);
    check("rst_alu_in2", a_alu_in2, 32'd0);
    check("rst_req_ready", 32'(a_req_ready), 32'd0);
    tick(1);
    rst = 1'b1; a_resp_ready = 1'b1; b_resp_ready = 1'b1;

    // Single op: 5+7, one-cycle response two edges after accept
    tick(1);
    q0.push_back(mk(add, 32'd5, 32'd7, 32'd12));
    tick(1);
    @(negedge clk); check("single_lat1_valid", 32'(a_resp_valid), 32'd0);
    @(negedge clk); check("single_lat2_valid", 32'(a_resp_valid), 32'd1);
    @(negedge clk); check("single_one_cycle", 32'(a_resp_valid), 32'd0);
    wait_idle_a("single_idle");

    // Async reset with S1 and S2 full and a request pending
    a_resp_ready = 1'b0;
    q1.push_back(mk(oro, 32'h1, 32'h2, 32'h3));
    q1.push_back(mk(oro, 32'h4, 32'h8, 32'hC));
    q1.push_back(mk(oro, 32'h10, 32'h20, 32'h30));
    tick(2);
    #2;
    check("pre_rst_resp_valid", 32'(a_resp_valid), 32'd1);
    rst = 1'b0;
    #1;
    check("async_rst_resp_valid", 32'(a_resp_valid), 32'd0);
    check("async_rst_req_ready", 32'(a_req_ready), 32'd0);
    q1.delete(); sb_a.delete();
    tick(2);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_resp_data", a_resp_data, 32'd0);
    check("post_rst_resp_id", 32'(a_resp_id), 32'd0);
    tick(1);
    a_resp_ready = 1'b1;

    // Round-robin: both requesters busy, one op per cycle
    acc_log.delete();
    base = resp_cnt_a;
    q0.push_back(mk(sub, 32'd10, 32'd3, 32'd7));
    q0.push_back(mk(sub, 32'd10, 32'd3, 32'd7));
    q1.push_back(mk(sra, 32'h8000_0000, 32'd4, 32'hF800_0000));
    q1.push_back(mk(sra, 32'h8000_0000, 32'd4, 32'hF800_0000));
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rr_back_to_back", 32'(a_resp_valid), 32'd1);
    end
    wait_idle_a("rr_idle");
    check("rr_accept_count", 32'(acc_log.size()), 32'd4);
    for (int k = 0; k < 4 && k < acc_log.size(); k++) check("rr_order", 32'(acc_log[k]), 32'(exp_order[k]));
    check("rr_resp_count", 32'(resp_cnt_a - base), 32'd4);

    // Backpressure: three ops from req1, consumer stalled for four cycles
    base = resp_cnt_a;
    a_resp_ready = 1'b0;
    q1.push_back(mk(oro, 32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF));
    q1.push_back(mk(sl, 32'd3, 32'd33, 32'd6));
    q1.push_back(mk(ando, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00));
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("bp_resp_valid", 32'(a_resp_valid), 32'd1);
      check("bp_resp_data_stable", a_resp_data, 32'h0000_00FF);
      check("bp_resp_id_stable", 32'(a_resp_id), 32'd1);
      check("bp_req_ready", 32'(a_req_ready), 32'd0);
    end
    tick(1);
    a_resp_ready = 1'b1;
    wait_idle_a("bp_idle");
    check("bp_resp_count", 32'(resp_cnt_a - base), 32'd3);

    // Flush with S1 and S2 valid and req0 waiting
    base = resp_cnt_a;
    q1.push_back(mk(add, 32'h10, 32'h20, 32'h30));
    q1.push_back(mk(sub, 32'h100, 32'h1, 32'hFF));
    tick(2);
    flush = 1'b1;
    q0.push_back(mk(xoro, 32'hFF, 32'h0F, 32'hF0));
    @(negedge clk);
    check("flush_no_accept", 32'(a_req_ready), 32'd0);
    tick(1);
    flush = 1'b0;
    check("flush_killed", 32'(sb_a.size()), 32'd1);
    if (sb_a.size() != 0) void'(sb_a.pop_front());
    @(negedge clk);
    check("flush_resp_cleared", 32'(a_resp_valid), 32'd0);
    wait_idle_a("flush_idle");
    check("flush_resp_count", 32'(resp_cnt_a - base), 32'd2);

    // Wrap on NREQ=3: ptr reaches 2, then requests on 0 and 2
    b_req_fn[1] = add;  b_req_in1[1] = 32'd1;  b_req_in2[1] = 32'd1;
    sb_b.push_back(mk_rsp(1, 32'd2));
    b_step(3'b010, 3'b010, "wrap_grant1");
    b_req_fn[0] = ando; b_req_in1[0] = 32'hF0; b_req_in2[0] = 32'h3C;
    b_req_fn[2] = sub;  b_req_in1[2] = 32'd9;  b_req_in2[2] = 32'd4;
    sb_b.push_back(mk_rsp(2, 32'd5));
    sb_b.push_back(mk_rsp(0, 32'h30));
    b_step(3'b101, 3'b100, "wrap_grant2");
    b_step(3'b001, 3'b001, "wrap_grant0");
    tick(1);
    b_req_fn[0] = oro;  b_req_in1[0] = 32'h1;   b_req_in2[0] = 32'h2;
    b_req_fn[1] = sl;   b_req_in1[1] = 32'd1;   b_req_in2[1] = 32'd4;
    b_req_fn[2] = sr;   b_req_in1[2] = 32'h100; b_req_in2[2] = 32'd4;
    b_req_valid = 3'b111;
    sb_b.push_back(mk_rsp(1, 32'd16));
    sb_b.push_back(mk_rsp(2, 32'h10));
    sb_b.push_back(mk_rsp(0, 32'd3));
    @(negedge clk);
    check("wrap_ptr_is_1", 32'(b_req_ready), 32'(3'b010));
    b_step(3'b101, 3'b100, "wrap_next2");
    b_step(3'b001, 3'b001, "wrap_next0");
    tick(1);
    b_req_valid = '0;
    for (int t = 0; t < 20 && sb_b.size() != 0; t++) @(negedge clk);
    check("wrap_sb_drained", 32'(sb_b.size()), 32'd0);
    check("wrap_resp_count", 32'(resp_cnt_b), 32'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
